// File: rtl/fwd_pkg.sv
// Shared types and select codes for the EX-stage forwarding / load-use controller.
// Stage-info bundle carried alongside the EX, MEM and WB pipeline stages.
package fwd_pkg;

    localparam int FWD_RA_W  = 5;
    localparam int FWD_SEL_W = 2;

    localparam logic [FWD_SEL_W-1:0] SEL_REGFILE = 2'b00;
    localparam logic [FWD_SEL_W-1:0] SEL_EXMEM   = 2'b01;
    localparam logic [FWD_SEL_W-1:0] SEL_MEMWB   = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [FWD_RA_W-1:0] rs;
        logic [FWD_RA_W-1:0] rt;
        logic                use_rs;
        logic                use_rt;
        logic [FWD_RA_W-1:0] dst;
        logic                wen;
        logic                is_load;
    } stage_t;

    // Loads sitting in MEM have no data yet, so only WB may supply them.
    function automatic logic [FWD_SEL_W-1:0] fwd_sel(
        input stage_t              ex,
        input stage_t              mem,
        input stage_t              wb,
        input logic [FWD_RA_W-1:0] src,
        input logic                use_src
    );
        logic live;
        live = ex.valid && use_src && (src != '0);
        if (live && mem.valid && mem.wen && !mem.is_load && mem.dst == src)
            return SEL_EXMEM;
        else if (live && wb.valid && wb.wen && wb.dst == src)
            return SEL_MEMWB;
        else
            return SEL_REGFILE;
    endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One resettable pipeline register holding the stage-info bundle.
module fwd_stage_reg
    import fwd_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  stage_t d_i,
    output stage_t q_o
);

    stage_t info_q;

    always_ff @(posedge clk) begin
        if (rst)
            info_q <= '0;
        else
            info_q <= d_i;
    end

    assign q_o = info_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selects and load-use stall for a 5-stage pipeline.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int RA_W  = FWD_RA_W,
    parameter int SEL_W = FWD_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  id_dst,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel
);

    stage_t ex_d;
    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;
    logic   ld_hit;

    always_comb begin
        ld_hit = ex_q.valid && ex_q.is_load && ex_q.wen && (ex_q.dst != '0)
              && ((id_use_rs && id_rs == ex_q.dst)
              ||  (id_use_rt && id_rt == ex_q.dst));
        stall  = !rst && id_valid && !flush && ld_hit;
    end

    // Stalled or flushed instructions enter EX as an all-zero bubble.
    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.valid   = 1'b1;
            ex_d.rs      = id_rs;
            ex_d.rt      = id_rt;
            ex_d.use_rs  = id_use_rs;
            ex_d.use_rt  = id_use_rt;
            ex_d.dst     = id_dst;
            ex_d.wen     = id_wen;
            ex_d.is_load = id_is_load;
        end
    end

    always_comb begin
        fwd_a_sel = SEL_REGFILE;
        fwd_b_sel = SEL_REGFILE;
        if (!rst) begin
            fwd_a_sel = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs, ex_q.use_rs);
            fwd_b_sel = fwd_sel(ex_q, mem_q, wb_q, ex_q.rt, ex_q.use_rt);
        end
    end

    fwd_stage_reg u_ex (
        .clk (clk),
        .rst (rst),
        .d_i (ex_d),
        .q_o (ex_q)
    );

    fwd_stage_reg u_mem (
        .clk (clk),
        .rst (rst),
        .d_i (ex_q),
        .q_o (mem_q)
    );

    fwd_stage_reg u_wb (
        .clk (clk),
        .rst (rst),
        .d_i (mem_q),
        .q_o (wb_q)
    );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: an age-ordered model of in-flight instructions predicts
// stall and operand selects; a negedge monitor compares against the DUT.
module tb_fwd_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       wen;
        logic       ld;
    } ins_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_dst;
    logic       id_wen;
    logic       id_is_load;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

    always #5 clk = ~clk;

    fwd_hazard_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_dst     (id_dst),
        .id_wen     (id_wen),
        .id_is_load (id_is_load),
        .flush      (flush),
        .stall      (stall),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel)
    );

    // age 0 = in EX, age 1 = in MEM, age 2 = in WB
    ins_t pipe [3];
    ins_t prev_ins;
    logic prev_rst;
    logic prev_flush;
    logic prev_stall;
    exp_t sb [$];
    int   checks;
    int   failures;
    logic last_stall;

    function automatic ins_t alu(input int rd, input int ra, input int rb);
        ins_t i;
        i = '{v:1'b1, rs:5'(ra), rt:5'(rb), urs:1'b1, urt:1'b1,
              dst:5'(rd), wen:1'b1, ld:1'b0};
        return i;
    endfunction

    function automatic ins_t lw(input int rd, input int base);
        ins_t i;
        i = '{v:1'b1, rs:5'(base), rt:5'(rd), urs:1'b1, urt:1'b0,
              dst:5'(rd), wen:1'b1, ld:1'b1};
        return i;
    endfunction

    function automatic ins_t nop();
        ins_t i;
        i = '0;
        return i;
    endfunction

    // Newest older producer wins; a load still in MEM cannot supply data.
    function automatic logic [1:0] model_sel(input logic [4:0] src, input logic u);
        if (!pipe[0].v || !u || src == 5'd0)
            return 2'b00;
        for (int age = 1; age <= 2; age++) begin
            if (pipe[age].v && pipe[age].wen && pipe[age].dst == src
                && !(age == 1 && pipe[age].ld))
                return (age == 1) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic logic model_stall(input ins_t id, input logic fl);
        ins_t e;
        e = pipe[0];
        if (!id.v || fl || !e.v || !e.ld || !e.wen || e.dst == 5'd0)
            return 1'b0;
        return (id.urs && id.rs == e.dst) || (id.urt && id.rt == e.dst);
    endfunction

    task automatic step(input ins_t ins, input logic fl, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        if (prev_rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (prev_ins.v && !prev_flush && !prev_stall) ? prev_ins : '0;
        end
        rst        = r;
        flush      = fl;
        id_valid   = ins.v;
        id_rs      = ins.rs;
        id_rt      = ins.rt;
        id_use_rs  = ins.urs;
        id_use_rt  = ins.urt;
        id_dst     = ins.dst;
        id_wen     = ins.wen;
        id_is_load = ins.ld;
        e.stall = model_stall(ins, fl);
        e.a     = model_sel(pipe[0].rs, pipe[0].urs);
        e.b     = model_sel(pipe[0].rt, pipe[0].urt);
        if (r) e = '0;
        sb.push_back(e);
        prev_ins   = ins;
        prev_rst   = r;
        prev_flush = fl;
        prev_stall = e.stall;
        last_stall = e.stall;
    endtask

    // A stalled instruction is held in ID and re-presented.
    task automatic issue(input ins_t ins, input logic fl);
        step(ins, fl, 1'b0);
        for (int n = 0; n < 3 && last_stall; n++)
            step(ins, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++)
            step(nop(), 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks += 3;
            if (stall !== e.stall) begin
                failures++;
                $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, e.stall);
            end
            if (fwd_a_sel !== e.a) begin
                failures++;
                $display("FAIL fwd_a_sel t=%0t got=%b exp=%b", $time, fwd_a_sel, e.a);
            end
            if (fwd_b_sel !== e.b) begin
                failures++;
                $display("FAIL fwd_b_sel t=%0t got=%b exp=%b", $time, fwd_b_sel, e.b);
            end
        end
    end

    initial begin
        ins_t ri;
        checks     = 0;
        failures   = 0;
        prev_rst   = 1'b1;
        prev_flush = 1'b0;
        prev_stall = 1'b0;
        prev_ins   = '0;
        last_stall = 1'b0;
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_dst = '0; id_wen = 1'b0; id_is_load = 1'b0;

        do_reset(2);
        // add -> dependent sub: EX/MEM forward on A
        issue(alu(3, 1, 2), 1'b0);
        issue(alu(4, 3, 5), 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        // add ; nop ; or $6,$0,$3: MEM/WB forward on B, $0 on A
        issue(alu(3, 1, 2), 1'b0);
        issue(nop(), 1'b0);
        issue(alu(6, 0, 3), 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        // two writers of $3: MEM beats WB on both operands
        issue(alu(3, 1, 2), 1'b0);
        issue(alu(3, 4, 5), 1'b0);
        issue(alu(7, 3, 3), 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        // load-use: one bubble then MEM/WB forward
        issue(lw(8, 1), 1'b0);
        issue(alu(9, 8, 2), 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        // load then flushed dependent: flush wins
        issue(lw(8, 1), 1'b0);
        issue(alu(9, 8, 2), 1'b1);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        // reset asserted in the stall cycle
        issue(lw(8, 1), 1'b0);
        step(alu(9, 8, 2), 1'b0, 1'b1);
        step(alu(9, 8, 2), 1'b0, 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        // writes to $0 must never forward or stall
        issue(lw(0, 1), 1'b0);
        issue(alu(5, 0, 0), 1'b0);
        issue(nop(), 1'b0);

        for (int n = 0; n < 3000; n++) begin
            ri.v   = ($urandom_range(0, 7) != 0);
            ri.rs  = 5'($urandom_range(0, 5));
            ri.rt  = 5'($urandom_range(0, 5));
            ri.urs = 1'($urandom_range(0, 1));
            ri.urt = 1'($urandom_range(0, 1));
            ri.dst = 5'($urandom_range(0, 5));
            ri.wen = ($urandom_range(0, 4) != 0);
            ri.ld  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0)
                step(ri, 1'($urandom_range(0, 1)), 1'b1);
            else if ($urandom_range(0, 1) == 0)
                issue(ri, ($urandom_range(0, 7) == 0));
            else
                step(ri, ($urandom_range(0, 7) == 0), 1'b0);
        end

        @(posedge clk);
        #1;
        id_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
